// File: rtl/usb_rx_frame_if.sv
// Nibble-lane receive bundle for usb_rx_frame.
// master drives en/rxd, slave returns bytes, pulses and stats.
interface usb_rx_frame_if;
  logic        en;
  logic [3:0]  rxd;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_sof;
  logic        rx_eof;
  logic        frame_ok;
  logic        frame_err;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  modport master (
    output en, rxd,
    input  rx_data, rx_vld, rx_sof, rx_eof,
    input  frame_ok, frame_err, busy,
    input  frame_cnt, err_cnt
  );

  modport slave (
    input  en, rxd,
    output rx_data, rx_vld, rx_sof, rx_eof,
    output frame_ok, frame_err, busy,
    output frame_cnt, err_cnt
  );
endinterface

// File: rtl/usb_rx_frame.sv
// Sync-hunting, length-prefixed nibble framer with additive checksum.
// Define USB_RX_STAT_EN to build the saturating frame/error counters.
module usb_rx_frame #(
  parameter logic [3:0] SYNC_H  = 4'hA,
  parameter logic [3:0] SYNC_L  = 4'h5,
  parameter logic [7:0] MAX_LEN = 8'h40
) (
  input logic           clk,
  input logic           rst_n,
  usb_rx_frame_if.slave bus
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_SYNC,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_CSUM_H,
    S_CSUM_L
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_rxd_q;
  logic [3:0] r_hi;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [7:0] r_sum;
  logic [7:0] r_data;
  logic       r_vld;
  logic       r_sof;
  logic       r_eof;
  logic       r_ok;
  logic       r_err;

  logic [7:0] w_pair;
  logic       w_busy;
  logic       w_last;
  logic       w_hi_st;
  logic       w_len_st;
  logic       w_vld;
  logic       w_sof;
  logic       w_eof;
  logic       w_ok;
  logic       w_err;

  assign w_pair   = {r_hi, r_rxd_q};
  assign w_busy   = !(r_state == S_HUNT ||
                      r_state == S_SYNC);
  assign w_last   = (r_cnt + 8'd1) == r_len;
  assign w_len_st = r_state == S_LEN_L;
  assign w_hi_st  = r_state == S_LEN_H  ||
                    r_state == S_DATA_H ||
                    r_state == S_CSUM_H;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HUNT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_HUNT;
    if (bus.en) begin
      unique case (r_state)
        S_HUNT:
          w_next = (r_rxd_q == SYNC_H) ? S_SYNC : S_HUNT;
        S_SYNC:
          if (r_rxd_q == SYNC_L)      w_next = S_LEN_H;
          else if (r_rxd_q == SYNC_H) w_next = S_SYNC;
          else                        w_next = S_HUNT;
        S_LEN_H:
          w_next = S_LEN_L;
        S_LEN_L:
          if (w_pair > MAX_LEN)     w_next = S_HUNT;
          else if (w_pair == 8'd0)  w_next = S_CSUM_H;
          else                      w_next = S_DATA_H;
        S_DATA_H:
          w_next = S_DATA_L;
        S_DATA_L:
          w_next = w_last ? S_CSUM_H : S_DATA_H;
        S_CSUM_H:
          w_next = S_CSUM_L;
        S_CSUM_L:
          w_next = S_HUNT;
        default:
          w_next = S_HUNT;
      endcase
    end
  end

  // Dropping en mid-frame aborts with an error instead of any strobe.
  always_comb begin
    w_vld = 1'b0;
    w_sof = 1'b0;
    w_eof = 1'b0;
    w_ok  = 1'b0;
    w_err = 1'b0;
    if (!bus.en) begin
      w_err = w_busy;
    end else begin
      unique case (r_state)
        S_LEN_L: w_err = w_pair > MAX_LEN;
        S_DATA_L: begin
          w_vld = 1'b1;
          w_sof = r_cnt == 8'd0;
          w_eof = r_cnt == (r_len - 8'd1);
        end
        S_CSUM_L: begin
          w_ok  = w_pair == r_sum;
          w_err = w_pair != r_sum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_q <= '0;
      r_hi    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rxd_q <= bus.rxd;
      r_vld   <= w_vld;
      r_sof   <= w_sof;
      r_eof   <= w_eof;
      r_ok    <= w_ok;
      r_err   <= w_err;
      if (w_vld) r_data <= w_pair;
      if (bus.en) begin
        unique case (1'b1)
          w_hi_st: r_hi <= r_rxd_q;
          w_len_st: begin
            r_len <= w_pair;
            r_cnt <= '0;
            r_sum <= '0;
          end
          w_vld: begin
            r_sum <= r_sum + w_pair;
            r_cnt <= r_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_vld    = r_vld;
  assign bus.rx_sof    = r_sof;
  assign bus.rx_eof    = r_eof;
  assign bus.frame_ok  = r_ok;
  assign bus.frame_err = r_err;
  assign bus.busy      = w_busy;

`ifdef USB_RX_STAT_EN
  logic [15:0] r_fcnt;
  logic [15:0] r_ecnt;

  // Counters step on the same edge that raises the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= '0;
      r_ecnt <= '0;
    end else begin
      if (w_ok && r_fcnt != 16'hFFFF)
        r_fcnt <= r_fcnt + 16'd1;
      if (w_err && r_ecnt != 16'hFFFF)
        r_ecnt <= r_ecnt + 16'd1;
    end
  end

  assign bus.frame_cnt = r_fcnt;
  assign bus.err_cnt   = r_ecnt;
`else
  assign bus.frame_cnt = 16'h0000;
  assign bus.err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_rx_frame.sv
// Directed plus randomized frames against a byte-list reference model.
// Checks strobes, latency, pulses, busy, abort and reset behaviour.
module tb_usb_rx_frame;

  typedef logic [7:0] bq_t[$];

  localparam int MAXL = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_f = 0;
  int   exp_e = 0;

  usb_rx_frame_if bus ();

  usb_rx_frame dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_data[$];
  logic       m_sof[$];
  logic       m_eof[$];
  int         m_vcyc[$];
  int         m_ok[$];
  int         m_err[$];
  bit         busy_seen = 0;
  bit         prev_vld = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rx_vld) begin
      m_data.push_back(bus.rx_data);
      m_sof.push_back(bus.rx_sof);
      m_eof.push_back(bus.rx_eof);
      m_vcyc.push_back(cyc);
      chk("vld_spacing", {31'd0, prev_vld}, 32'd0);
    end
    if (bus.frame_ok || bus.frame_err)
      chk("ok_err_excl",
          {31'd0, bus.frame_ok & bus.frame_err}, 32'd0);
    if (bus.frame_ok)  m_ok.push_back(cyc);
    if (bus.frame_err) m_err.push_back(cyc);
    if (bus.busy) busy_seen = 1;
    prev_vld = bus.rx_vld;
  end

  task automatic mclear();
    m_data.delete();
    m_sof.delete();
    m_eof.delete();
    m_vcyc.delete();
    m_ok.delete();
    m_err.delete();
    busy_seen = 0;
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    bus.rxd = n;
  endtask

  task automatic idle(input int n);
    repeat (n) nib(4'h0);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef USB_RX_STAT_EN
    chk({tag, "_fcnt"}, {16'd0, bus.frame_cnt}, exp_f);
    chk({tag, "_ecnt"}, {16'd0, bus.err_cnt}, exp_e);
`else
    chk({tag, "_fcnt"}, {16'd0, bus.frame_cnt}, 32'd0);
    chk({tag, "_ecnt"}, {16'd0, bus.err_cnt}, 32'd0);
`endif
  endtask

  function automatic logic [7:0] bsum(input bq_t p);
    int s = 0;
    foreach (p[i]) s += int'(p[i]);
    return 8'(s);
  endfunction

  // Sends one frame and compares what came out against the model.
  task automatic run_frame(input string tag,
                           input int npre,
                           input bq_t pay,
                           input logic [7:0] len,
                           input logic [7:0] csum);
    int  lo_cyc[$];
    int  end_cyc;
    int  n;
    bit  ok_exp;
    mclear();
    repeat (npre) nib(4'hA);
    nib(4'hA);
    nib(4'h5);
    nib(len[7:4]);
    nib(len[3:0]);
    end_cyc = cyc;
    if (int'(len) > MAXL) begin
      n = 0;
      ok_exp = 0;
    end else begin
      n = int'(len);
      for (int i = 0; i < n; i++) begin
        nib(pay[i][7:4]);
        nib(pay[i][3:0]);
        lo_cyc.push_back(cyc);
      end
      nib(csum[7:4]);
      nib(csum[3:0]);
      end_cyc = cyc;
      ok_exp = (bsum(pay) == csum);
    end
    idle(6);
    if (ok_exp) exp_f++;
    else        exp_e++;
    chk({tag, "_nvld"}, m_data.size(), n);
    if (m_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_data"}, {24'd0, m_data[i]},
            {24'd0, pay[i]});
        chk({tag, "_sof"}, {31'd0, m_sof[i]},
            (i == 0) ? 32'd1 : 32'd0);
        chk({tag, "_eof"}, {31'd0, m_eof[i]},
            (i == n - 1) ? 32'd1 : 32'd0);
        chk({tag, "_vcyc"}, m_vcyc[i], lo_cyc[i] + 2);
      end
    end
    chk({tag, "_nok"}, m_ok.size(), ok_exp ? 1 : 0);
    chk({tag, "_nerr"}, m_err.size(), ok_exp ? 0 : 1);
    if (ok_exp && m_ok.size() == 1)
      chk({tag, "_okcyc"}, m_ok[0], end_cyc + 2);
    if (!ok_exp && m_err.size() == 1)
      chk({tag, "_errcyc"}, m_err[0], end_cyc + 2);
    chk({tag, "_busy_seen"}, {31'd0, busy_seen}, 32'd1);
    chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    chk_cnt(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, {24'd0, bus.rx_data}, 32'd0);
    chk({tag, "_ctl"},
        {26'd0, bus.rx_vld, bus.rx_sof, bus.rx_eof,
         bus.frame_ok, bus.frame_err, bus.busy}, 32'd0);
    chk({tag, "_cnt"}, {bus.frame_cnt, bus.err_cnt},
        32'd0);
  endtask

  bq_t        p;
  logic [7:0] l;
  logic [7:0] cs;
  int         a;

  initial begin
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.rxd = 4'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n  = 1'b1;
    bus.en = 1'b1;
    idle(100);

    p = '{8'h12, 8'h34, 8'h56};
    run_frame("f3_good", 0, p, 8'd3, 8'h9C);
    run_frame("f3_bad", 0, p, 8'd3, 8'h9D);

    p.delete();
    run_frame("len41", 0, p, 8'h41, 8'h00);

    for (int i = 0; i < MAXL; i++)
      p.push_back(8'($urandom));
    run_frame("len40", 0, p, 8'h40, bsum(p));

    p.delete();
    run_frame("len0", 0, p, 8'd0, 8'h00);

    p = '{8'h7F};
    run_frame("len1", 0, p, 8'd1, 8'h7F);

    p = '{8'h3C, 8'hE1};
    run_frame("lead_a", 2, p, 8'd2, 8'h1D);

    p = '{8'hA5, 8'hA5, 8'h0A};
    run_frame("sync_in_pay", 0, p, 8'd3, 8'h54);

    mclear();
    nib(4'hA);
    nib(4'h3);
    nib(4'h5);
    idle(6);
    chk("a35_busy", {31'd0, busy_seen}, 32'd0);
    chk("a35_evt", m_data.size() + m_ok.size() +
        m_err.size(), 32'd0);

    // en drop after two of three payload bytes
    mclear();
    nib(4'hA); nib(4'h5); nib(4'h0); nib(4'h3);
    nib(4'h1); nib(4'h1);
    nib(4'h2); nib(4'h2);
    nib(4'h3);
    @(negedge clk);
    bus.en  = 1'b0;
    bus.rxd = 4'h0;
    a = cyc;
    idle(5);
    exp_e++;
    chk("abort_nvld", m_data.size(), 32'd2);
    if (m_data.size() == 2)
      chk("abort_b1", {24'd0, m_data[1]}, 32'h22);
    chk("abort_nerr", m_err.size(), 32'd1);
    if (m_err.size() == 1)
      chk("abort_errcyc", m_err[0], a + 1);
    chk("abort_nok", m_ok.size(), 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk_cnt("abort");
    bus.en = 1'b1;
    idle(2);
    p = '{8'h01, 8'h02};
    run_frame("post_abort", 0, p, 8'd2, 8'h03);

    // async reset in the middle of the payload
    mclear();
    nib(4'hA); nib(4'h5); nib(4'h0); nib(4'h3);
    nib(4'hC); nib(4'h3);
    nib(4'h4); nib(4'h4);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.rxd = 4'h0;
    #1;
    chk_zero("midrst");
    exp_f = 0;
    exp_e = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_nvld", m_data.size(), 32'd1);
    if (m_data.size() == 1)
      chk("midrst_b0", {24'd0, m_data[0]}, 32'hC3);
    chk("midrst_pulse", m_ok.size() + m_err.size(),
        32'd0);
    p = '{8'hFF, 8'h02};
    run_frame("post_rst", 0, p, 8'd2, 8'h01);

    for (int k = 0; k < 20; k++) begin
      p.delete();
      l = 8'($urandom_range(0, MAXL + 2));
      if (int'(l) <= MAXL)
        for (int i = 0; i < int'(l); i++)
          p.push_back(8'($urandom));
      cs = bsum(p);
      if ($urandom_range(0, 3) == 0)
        cs = cs ^ (8'd1 << $urandom_range(0, 7));
      run_frame("rand", 0, p, l, cs);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
